// File: rtl/and3_response_checker.sv
// Checks a 3-input AND against observed outputs over a run of MAX_SAMPLES valid samples.
// Results appear one cycle after each sampled edge; there is no backpressure, and samples outside CHECK are dropped.
module and3_response_checker #(
    parameter int MAX_SAMPLES = 64,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       cov_mask,
    output logic             first_err_valid,
    output logic [3:0]       first_err_vec
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [15:0]      MAX_CNT = 16'(MAX_SAMPLES);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       cov_q, cov_d;
    logic             fev_q, fev_d;
    logic [3:0]       fvec_q, fvec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             mismatch;

    assign mismatch = (d != (a & b & c));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cov_d   = cov_q;
        fev_d   = fev_q;
        fvec_d  = fvec_q;
        case (state_q)
            IDLE, DONE: begin
                // A new run clears all results; in_valid on this edge is not a sample.
                if (start) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                    err_d   = '0;
                    cov_d   = '0;
                    fev_d   = 1'b0;
                    fvec_d  = '0;
                end
            end
            CHECK: begin
                if (in_valid) begin
                    cnt_d            = cnt_q + 16'd1;
                    cov_d[{a, b, c}] = 1'b1;
                    if (mismatch) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!fev_q) begin
                            fev_d  = 1'b1;
                            fvec_d = {a, b, c, d};
                        end
                    end
                    if (cnt_d == MAX_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0) && (cov_d == 8'hFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            cov_q   <= '0;
            fev_q   <= 1'b0;
            fvec_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cov_q   <= cov_d;
            fev_q   <= fev_d;
            fvec_q  <= fvec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign cov_mask        = cov_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fvec_q;

endmodule

// File: tb/tb_and3_response_checker.sv
// Directed bench: a default checker plus an ERR_W=2 instance sharing the same stimulus.
module tb_and3_response_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;

    logic       busy, done, pass, fev;
    logic [7:0] err_count, cov_mask;
    logic [3:0] fvec;

    logic       busy2, done2, pass2, fev2;
    logic [1:0] err2;
    logic [7:0] cov2;
    logic [3:0] fvec2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    and3_response_checker dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .cov_mask(cov_mask), .first_err_valid(fev), .first_err_vec(fvec)
    );

    and3_response_checker #(.MAX_SAMPLES(64), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .cov_mask(cov2), .first_err_valid(fev2), .first_err_vec(fvec2)
    );

    // Inputs change on negedge; outputs are read on the following negedge.
    task automatic send(input logic [2:0] p, input logic dv);
        {a, b, c} = p;
        d         = dv;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; {a, b, c, d} = 4'b1101;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        total++;
        if ({busy, done, pass, fev} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, fev});
        end
        total++;
        if ({err_count, cov_mask, fvec} !== 20'h0) begin
            bad++; $display("FAIL reset_regs: got err=%h cov=%h vec=%h want 0", err_count, cov_mask, fvec);
        end
    endtask

    task automatic test_clean_run();
        // in_valid with a mismatching sample on the start edge must be ignored.
        {a, b, c, d} = 4'b1101;
        in_valid = 1'b1;
        pulse_start();
        in_valid = 1'b0;
        total++;
        if ({busy, done, err_count, cov_mask} !== {2'b10, 8'h00, 8'h00}) begin
            bad++; $display("FAIL start_edge_ignore: got busy=%b done=%b err=%h cov=%h want 1 0 00 00",
                            busy, done, err_count, cov_mask);
        end
        for (int i = 0; i < 63; i++) begin
            send(3'(i % 8), (i % 8) == 7);
        end
        total++;
        if ({busy, done, pass} !== 3'b100) begin
            bad++; $display("FAIL clean_63: got busy/done/pass=%b want 100", {busy, done, pass});
        end
        send(3'd7, 1'b1);
        total++;
        if ({busy, done, pass, fev} !== 4'b0110 || err_count !== 8'd0 || cov_mask !== 8'hFF) begin
            bad++; $display("FAIL clean_done: got flags=%b err=%h cov=%h want 0110 00 ff",
                            {busy, done, pass, fev}, err_count, cov_mask);
        end
        // Samples in DONE are dropped and outputs hold.
        send(3'd0, 1'b1);
        total++;
        if ({done, pass} !== 2'b11 || err_count !== 8'd0) begin
            bad++; $display("FAIL done_hold: got done/pass=%b err=%h want 11 00", {done, pass}, err_count);
        end
    endtask

    task automatic test_stuck_110();
        pulse_start();
        total++;
        if ({busy, done, pass, cov_mask} !== {3'b100, 8'h00}) begin
            bad++; $display("FAIL restart_clear: got flags=%b cov=%h want 100 00", {busy, done, pass}, cov_mask);
        end
        for (int i = 0; i < 64; i++) begin
            send(3'(i % 8), ((i % 8) == 7) || ((i % 8) == 6));
            if (i == 20) begin
                total++;
                if (pass !== 1'b0) begin
                    bad++; $display("FAIL pass_in_check: got %b want 0", pass);
                end
            end
        end
        total++;
        if (err_count !== 8'd8 || pass !== 1'b0 || done !== 1'b1) begin
            bad++; $display("FAIL stuck_err: got err=%0d pass=%b done=%b want 8 0 1", err_count, pass, done);
        end
        total++;
        if (fev !== 1'b1 || fvec !== 4'b1101) begin
            bad++; $display("FAIL stuck_first: got valid=%b vec=%b want 1 1101", fev, fvec);
        end
    endtask

    task automatic test_partial_cov();
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            send(3'(i % 7), 1'b0);
        end
        total++;
        if (cov_mask !== 8'h7F || err_count !== 8'd0 || pass !== 1'b0 || done !== 1'b1) begin
            bad++; $display("FAIL partial_cov: got cov=%h err=%0d pass=%b done=%b want 7f 0 0 1",
                            cov_mask, err_count, pass, done);
        end
    endtask

    task automatic test_saturate();
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            send(3'(i % 8), (i % 8) != 7);
        end
        total++;
        if (err2 !== 2'b11 || pass2 !== 1'b0 || done2 !== 1'b1 || busy2 !== 1'b0) begin
            bad++; $display("FAIL sat_err2: got err=%b pass=%b done=%b busy=%b want 11 0 1 0",
                            err2, pass2, done2, busy2);
        end
        total++;
        if (cov2 !== 8'hFF || fev2 !== 1'b1 || fvec2 !== 4'b0001) begin
            bad++; $display("FAIL sat_misc2: got cov=%h valid=%b vec=%b want ff 1 0001", cov2, fev2, fvec2);
        end
        total++;
        if (err_count !== 8'd64) begin
            bad++; $display("FAIL sat_err8: got %0d want 64", err_count);
        end
    endtask

    task automatic test_gaps_start();
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            if (i % 3 == 0) @(negedge clk);
            if (i == 30) start = 1'b1;
            send(3'(i % 8), (i % 8) == 7);
            start = 1'b0;
            if (i == 62) begin
                total++;
                if ({busy, done} !== 2'b10) begin
                    bad++; $display("FAIL gaps_63: got busy/done=%b want 10", {busy, done});
                end
            end
        end
        total++;
        if ({done, pass, fev} !== 3'b110 || err_count !== 8'd0 || cov_mask !== 8'hFF) begin
            bad++; $display("FAIL gaps_done: got done/pass/fev=%b err=%0d cov=%h want 110 0 ff",
                            {done, pass, fev}, err_count, cov_mask);
        end
    endtask

    task automatic test_mid_reset();
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            send(3'(i % 8), 1'b1);
        end
        total++;
        if (err_count !== 8'd18 || fev !== 1'b1) begin
            bad++; $display("FAIL pre_reset: got err=%0d fev=%b want 18 1", err_count, fev);
        end
        rst = 1'b1; start = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        total++;
        if ({busy, done, pass, fev} !== 4'b0000 || err_count !== 8'd0 || cov_mask !== 8'd0 || fvec !== 4'd0) begin
            bad++; $display("FAIL mid_reset: got flags=%b err=%0d cov=%h vec=%b want 0000 0 00 0000",
                            {busy, done, pass, fev}, err_count, cov_mask, fvec);
        end
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            send(3'(7 - (i % 8)), (i % 8) == 0);
        end
        total++;
        if ({done, pass} !== 2'b11 || err_count !== 8'd0 || cov_mask !== 8'hFF) begin
            bad++; $display("FAIL after_reset_run: got done/pass=%b err=%0d cov=%h want 11 0 ff",
                            {done, pass}, err_count, cov_mask);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_run();
        test_stuck_110();
        test_partial_cov();
        test_saturate();
        test_gaps_start();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/and3_response_checker.md
AND3_RESPONSE_CHECKER -- requirements
Module: and3_response_checker

Interface
- REQ-001: The block SHALL use one clock and a synchronous, active-high reset.
- REQ-002: Parameter MAX_SAMPLES, default 64, SHALL set the number of valid samples per run; legal range is 8..65535.
- REQ-003: Parameter ERR_W, default 8, SHALL set the width of err_count.
- REQ-004: clk  input  1  rising-edge clock; all state updates on this edge.
- REQ-005: rst  input  1  synchronous active-high reset.
- REQ-006: start  input  1  single-cycle request to begin a checking run.
- REQ-007: in_valid  input  1  marks a, b, c, d as a sample to check this cycle.
- REQ-008: a, b, c  input  1 each  stimulus bits applied to the 3-input AND under test.
- REQ-009: d  input  1  observed DUT output.
- REQ-010: busy  output  1  high in CHECK.
- REQ-011: done  output  1  high in DONE.
- REQ-012: pass  output  1  run verdict; valid while done=1.
- REQ-013: err_count  output  ERR_W  number of mismatches; saturates at all-ones.
- REQ-014: cov_mask  output  8  bit {a,b,c} set once that input combination has been checked.
- REQ-015: first_err_valid  output  1  high once a mismatch has been captured in the current run.
- REQ-016: first_err_vec  output  4  {a,b,c,d} of the first mismatching sample.

Function
- REQ-017: The FSM SHALL have states IDLE, CHECK and DONE, encoded in registers.
- REQ-018: In IDLE, start=1 SHALL move to CHECK next edge. The same edge SHALL clear the sample counter, err_count, cov_mask, first_err_valid and first_err_vec.
- REQ-019: In CHECK, each edge with in_valid=1 SHALL:
  - increment the sample counter;
  - set cov_mask[{a,b,c}];
  - flag a mismatch when d != (a & b & c).
- REQ-020: On a mismatch, err_count SHALL increment by 1 unless it is all-ones, in which case it holds.
- REQ-021: On the first mismatch of a run, first_err_vec SHALL capture {a,b,c,d} and first_err_valid SHALL go high; later mismatches SHALL NOT overwrite it.
- REQ-022: The valid sample that brings the counter to MAX_SAMPLES SHALL be checked normally, and the same edge SHALL move the FSM to DONE.
- REQ-023: In CHECK, edges with in_valid=0 SHALL leave all counters and the mask unchanged.
- REQ-024: start while in CHECK SHALL be ignored.
- REQ-025: in_valid outside CHECK SHALL be ignored, including on the IDLE->CHECK transition edge.
- REQ-026: In DONE, outputs SHALL hold and pass SHALL equal (err_count==0 && cov_mask==8'hFF).
- REQ-027: In DONE, start=1 SHALL restart: move to CHECK and clear state exactly as in REQ-018.
- REQ-028: pass SHALL be 0 in every state other than DONE.
- REQ-029: All outputs SHALL be registered. Effects of a sample SHALL be visible one cycle after the edge on which in_valid was sampled.
- REQ-030: The sample counter SHALL be 16 bits wide and SHALL NOT wrap within a run.

Reset
- REQ-031: rst=1 SHALL force state IDLE and clear every output to 0 and the sample counter to 0, on the next clock edge.
- REQ-032: rst SHALL take priority over start and in_valid on the same edge.
- REQ-033: rst asserted mid-CHECK SHALL abort the run with no verdict; the next start begins a fresh run.

Verification
- REQ-034: Reset, start, then 64 valid samples sweeping {a,b,c}=0..7 eight times with d=a&b&c -> done=1, pass=1, err_count=0, cov_mask=8'hFF, first_err_valid=0.
- REQ-035: As REQ-034 but d forced 1 for {a,b,c}=3'b110 on every occurrence -> err_count=8, pass=0, first_err_vec=4'b1101.
- REQ-036: 64 valid samples using only patterns 0..6, all correct -> cov_mask=8'h7F, err_count=0, pass=0.
- REQ-037: ERR_W=2, d inverted on all 64 samples -> err_count=2'b11 (saturated), pass=0.
- REQ-038: Interleave in_valid=0 gaps and pulse start mid-run -> sample count and results are identical to the gap-free run; done is reached after exactly 64 valid samples.
- REQ-039: Assert rst after 20 samples, then start a new correct run -> counters clear on the reset edge; the new run gives pass=1.
